// File: rtl/sa_tx_queue_regs.sv
// -----------------------------------------------------------------------------
// sa_tx_queue_regs
//
// Eight-entry, 57-bit compacting transaction queue for the system agent.
// New entries are appended behind the existing ones. Any set of slots can be
// retired in one cycle. Survivors shift toward slot 0 in age order, so slot 0
// always holds the oldest pending transaction. All slots are visible in
// parallel.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   in_en   append request for din this cycle
//   clear   per-slot retire mask, indexed as currently shown on dout/valid
//   din     57-bit entry to append (opaque to the queue)
//   dout    slot contents, [0] oldest; invalid slots read as zero
//   valid   thermometer-coded slot-occupied flags
//   count   number of valid entries, 0..8
//   full    count == 8
//   empty   count == 0
//   accept  combinational: in_en will be stored at the next edge
// -----------------------------------------------------------------------------
module sa_tx_queue_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_en,
    input  logic [7:0]  clear,
    input  logic [56:0] din,
    output logic [56:0] dout [7:0],
    output logic [7:0]  valid,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty,
    output logic        accept
);

    logic [56:0] data_q   [7:0];
    logic [56:0] nxt_data [7:0];
    logic [7:0]  eclr;
    logic [7:0]  surv;
    logic [3:0]  nk;
    logic [3:0]  nxt_count;
    logic [7:0]  nxt_valid;

    // Clear bits on empty slots carry no meaning and are masked off.
    assign eclr = clear & valid;
    assign surv = valid & ~eclr;

    // Compaction: survivors are packed into slots 0..k-1 in ascending original
    // index order, then the append (if any) lands in slot k.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment so no path can hold a stale value (no latch).
        nxt_data = '{default: '0};
        nk       = '0;
        accept   = 1'b0;
        // NOTE: blocking assignments here because nk is a running index that
        // later iterations must see updated within the same evaluation.
        for (int i = 0; i < 8; i++) begin
            if (surv[i]) begin
                nxt_data[nk[2:0]] = data_q[i];
                nk                = nk + 4'd1;
            end
        end
        accept = in_en & (nk < 4'd8);
        if (accept) begin
            nxt_data[nk[2:0]] = din;
        end
        nxt_count = nk + {3'b000, accept};
        nxt_valid = 8'((16'h0001 << nxt_count) - 16'h0001);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data slots are reset too, not just the valid flags,
            // because invalid slots must read as zero and never as X.
            data_q <= '{default: '0};
            valid  <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            data_q <= nxt_data;
            valid  <= nxt_valid;
            count  <= nxt_count;
            full   <= (nxt_count == 4'd8);
            empty  <= (nxt_count == 4'd0);
        end
    end

    assign dout = data_q;

endmodule

// File: tb/tb_sa_tx_queue_regs.sv
`timescale 1ns/1ps
module tb_sa_tx_queue_regs;

    logic        clk;
    logic        rst;
    logic        in_en;
    logic [7:0]  clear;
    logic [56:0] din;
    logic [56:0] dout [7:0];
    logic [7:0]  valid;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        accept;

    int checks = 0;
    int errors = 0;

    sa_tx_queue_regs dut (
        .clk    (clk),
        .rst    (rst),
        .in_en  (in_en),
        .clear  (clear),
        .din    (din),
        .dout   (dout),
        .valid  (valid),
        .count  (count),
        .full   (full),
        .empty  (empty),
        .accept (accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of pending entries, oldest first.
    logic [56:0] mq [$];
    logic [56:0] m_nq [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_nq = {};
            foreach (mq[i]) if (!clear[i]) m_nq.push_back(mq[i]);
            if (in_en && m_nq.size() < 8) m_nq.push_back(din);
            mq = m_nq;
        end
    end

    // Compare process: outputs are checked against the model every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            int          surv_n;
            logic [7:0]  exp_valid;
            surv_n    = 0;
            exp_valid = '0;
            foreach (mq[i]) if (!clear[i]) surv_n++;
            for (int i = 0; i < 8; i++) begin
                exp_valid[i] = (i < mq.size());
                check($sformatf("dout[%0d]", i), 64'(dout[i]),
                      (i < mq.size()) ? 64'(mq[i]) : 64'd0);
            end
            check("valid", 64'(valid), 64'(exp_valid));
            check("count", 64'(count), 64'(mq.size()));
            check("full", 64'(full), 64'(mq.size() == 8));
            check("empty", 64'(empty), 64'(mq.size() == 0));
            check("accept", 64'(accept), 64'(in_en && surv_n < 8));
        end
    end

    // Inputs are driven 1ns after a rising edge and held for one cycle.
    task automatic apply(input logic e, input logic [7:0] c, input logic [56:0] d);
        in_en = e;
        clear = c;
        din   = d;
        @(posedge clk);
        #1;
        in_en = 1'b0;
        clear = '0;
        din   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic fill_10_17();
        for (int i = 0; i < 8; i++) apply(1'b1, 8'h00, 57'(10 + i));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000ns");
        $fatal(1);
    end

    // Mixed directed vectors run through the model: {in_en, clear, din}.
    typedef struct packed {
        logic        e;
        logic [7:0]  c;
        logic [56:0] d;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs = '{
            '{1'b1, 8'h00, 57'h1AAAA_0000_0001},
            '{1'b1, 8'h00, 57'h0BBBB_FFFF_FFFF},
            '{1'b1, 8'h01, 57'd300},
            '{1'b1, 8'h00, 57'd301},
            '{1'b0, 8'h06, 57'd0},
            '{1'b1, 8'h00, 57'd302},
            '{1'b1, 8'hFF, 57'd303},
            '{1'b1, 8'h00, 57'h1FF_FFFF_FFFF_FFFF},
            '{1'b1, 8'h00, 57'd305},
            '{1'b1, 8'h02, 57'd306},
            '{1'b0, 8'h00, 57'd0},
            '{1'b0, 8'h07, 57'd0}
        };

        rst   = 1'b1;
        in_en = 1'b0;
        clear = '0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset count", 64'(count), 64'd0);
        check("reset empty", 64'(empty), 64'd1);
        check("reset valid", 64'(valid), 64'd0);
        @(posedge clk);
        #1;

        // Three appends.
        apply(1'b1, 8'h00, 57'd1);
        apply(1'b1, 8'h00, 57'd2);
        apply(1'b1, 8'h00, 57'd3);
        @(negedge clk);
        check("t1 dout0", 64'(dout[0]), 64'd1);
        check("t1 dout2", 64'(dout[2]), 64'd3);
        check("t1 dout3", 64'(dout[3]), 64'd0);
        check("t1 valid", 64'(valid), 64'h07);
        check("t1 count", 64'(count), 64'd3);
        @(posedge clk);
        #1;

        // Full queue rejects an append when nothing is cleared.
        do_reset();
        fill_10_17();
        in_en = 1'b1;
        din   = 57'd99;
        #1;
        check("t2 accept", 64'(accept), 64'd0);
        @(posedge clk);
        #1;
        in_en = 1'b0;
        din   = '0;
        @(negedge clk);
        check("t2 full", 64'(full), 64'd1);
        check("t2 dout7", 64'(dout[7]), 64'd17);
        check("t2 dout0", 64'(dout[0]), 64'd10);
        @(posedge clk);
        #1;

        // Clear slots 0 and 2 of a full queue.
        apply(1'b0, 8'b0000_0101, 57'd0);
        @(negedge clk);
        check("t3 dout0", 64'(dout[0]), 64'd11);
        check("t3 dout1", 64'(dout[1]), 64'd13);
        check("t3 dout5", 64'(dout[5]), 64'd17);
        check("t3 dout6", 64'(dout[6]), 64'd0);
        check("t3 count", 64'(count), 64'd6);
        @(posedge clk);
        #1;

        // Full queue: clear slot 7 and append in the same cycle.
        do_reset();
        fill_10_17();
        in_en = 1'b1;
        clear = 8'b1000_0000;
        din   = 57'd55;
        #1;
        check("t4 accept", 64'(accept), 64'd1);
        @(posedge clk);
        #1;
        in_en = 1'b0;
        clear = '0;
        din   = '0;
        @(negedge clk);
        check("t4 dout6", 64'(dout[6]), 64'd16);
        check("t4 dout7", 64'(dout[7]), 64'd55);
        check("t4 full", 64'(full), 64'd1);
        @(posedge clk);
        #1;

        // Clears on invalid slots are ignored.
        do_reset();
        apply(1'b1, 8'h00, 57'd1);
        apply(1'b1, 8'h00, 57'd2);
        apply(1'b1, 8'h00, 57'd3);
        apply(1'b0, 8'b1111_0000, 57'd0);
        @(negedge clk);
        check("t5 count", 64'(count), 64'd3);
        check("t5 valid", 64'(valid), 64'h07);
        check("t5 dout2", 64'(dout[2]), 64'd3);
        @(posedge clk);
        #1;

        // Asynchronous reset between edges.
        do_reset();
        for (int i = 1; i <= 5; i++) apply(1'b1, 8'h00, 57'(i));
        #2;
        rst = 1'b1;
        #1;
        check("t6 valid", 64'(valid), 64'd0);
        check("t6 count", 64'(count), 64'd0);
        check("t6 dout0", 64'(dout[0]), 64'd0);
        check("t6 empty", 64'(empty), 64'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(1'b1, 8'h00, 57'd77);
        @(negedge clk);
        check("t6 post dout0", 64'(dout[0]), 64'd77);
        check("t6 post count", 64'(count), 64'd1);
        @(posedge clk);
        #1;

        // Mixed vectors checked by the compare process.
        do_reset();
        foreach (vecs[i]) apply(vecs[i].e, vecs[i].c, vecs[i].d);
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_tx_queue_regs.md
# sa_tx_queue_regs

Eight-entry, 57-bit-wide compacting transaction queue used by the system agent to hold pending memory transactions. New transactions are appended behind the existing ones. Any combination of slots can be retired in one cycle through a per-slot clear vector. Surviving entries shift toward slot 0 in age order, so slot 0 always holds the oldest pending transaction. All eight slots are exposed in parallel for the agent's scheduling logic.

## Interface
- No parameters. Depth is fixed at 8 and width at 57.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_en`  in  1  request to append `din` this cycle.
- `clear`  in  8  per-slot retire mask. Bit i refers to slot i as currently shown on `dout`/`valid`.
- `din`  in  57  entry to append. The queue does not interpret it. System-agent layout: [3:0] IP owner, [7:4] TX ID, [8] type, [40:9] data, [56:41] address.
- `dout`  out  8×57 (unpacked [7:0])  slot contents. Slot 0 is the oldest. Invalid slots read as all-zero.
- `valid`  out  8  slot-occupied flags. Always thermometer-coded: bits 0..count-1 set.
- `count`  out  4  number of valid entries, 0–8.
- `full`  out  1  `count == 8`.
- `empty`  out  1  `count == 0`.
- `accept`  out  1  combinational. High when `in_en` will be stored at the next edge.

## Operation
- Effective clear: `eclr = clear & valid`. Clear bits on invalid slots are ignored.
- Survivors are slots with `valid[i] & ~eclr[i]`. Let k be the number of survivors.
- At the clock edge, survivors are written to slots 0..k-1 in ascending original-index order, so relative age is preserved.
- `accept = in_en & (k < 8)`. Because of the effective clear, an append and a clear in the same cycle succeed even when the queue is full.
- If `accept` is high, `din` is written to slot k and `valid[k]` is set.
- If `in_en` is high but `accept` is low (full, no effective clears), `din` is dropped and the state is unchanged.
- Slots at index ≥ the new count are zeroed, both data and valid.
- New count is `k + accept`.
- The queue never reorders entries by content, never inspects `din`, and never produces an X on `dout`.

## Timing
- Reset, asynchronous: all `dout` = 0, `valid` = 0, `count` = 0, `empty` = 1, `full` = 0. `accept` follows `in_en` once reset is released, since k = 0.
- All state updates on the rising `clk` edge. `dout`, `valid`, `count`, `full` and `empty` are registered.
- Latency: an accepted entry appears on `dout` the cycle after the edge that captured it.
- Clearing takes effect at the edge where `clear` is sampled. Shifting to close gaps completes in that same edge, giving single-cycle compaction with no bubbles.
- Simultaneous append and clear: the clear is applied first, then the append. With a full queue and one valid clear bit, the new entry lands in slot 7.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- `accept` is purely combinational from `in_en`, `clear` and the registered `valid`. It has no path from `din`.

## Test plan
- Reset, then `in_en`=1 with `din`=1,2,3 on consecutive cycles -> `dout[0..2]`=1,2,3; `valid`=8'b0000_0111; `count`=3; `dout[3..7]`=0.
- Fill with 10..17 (8 appends), then append 99 with `clear`=0 -> `accept`=0; contents unchanged; `full`=1.
- Full queue 10..17 with `clear`=8'b0000_0101 and no append -> next cycle `dout[0..5]`=11,13,14,15,16,17; `count`=6; `dout[6..7]`=0.
- Full queue 10..17 with `clear`=8'b1000_0000 plus append 55 -> `accept`=1; next cycle `dout[0..7]`=10..16,55; `full` stays 1.
- Queue holding 3 entries with `clear`=8'b1111_0000 -> no state change, since clears on invalid slots are ignored.
- Queue holding 5 entries, assert `rst` between clock edges -> `valid`=0, `count`=0 and `dout`=0 before the next edge. The first append after release lands in slot 0.
